// File: rtl/display_scheduler.sv
// -----------------------------------------------------------------------------
// display_scheduler
//
// Purpose:
//   Sequencer for the shared 3-bit display path between the dice and the
//   traffic lights. It time-slices the display between the two sources,
//   arbitrates the user roll button, gates the roll strobe towards the dice
//   and produces a registered display value.
//
// Ports:
//   clk     in   1  system clock, single domain
//   rst     in   1  synchronous reset, active-high
//   button  in   1  user roll request, already synchronous to clk
//   lights  in   3  traffic-light state (bit0 red, bit1 amber, bit2 green)
//   throw   in   3  live dice value, legal range 1..6
//   sel     out  1  display mux select, 1 = lights, 0 = dice
//   roll    out  1  button forwarded to the dice, only while a roll is granted
//   result  out  3  registered display value
//   busy    out  1  high while rolling or holding a captured throw
//
// Optional feature:
//   ROLL_TIMEOUT_EN - when defined, a roll held for 1000 cycles is forced into
//   HOLD and the button is ignored until it has been seen released. When not
//   defined, a roll lasts exactly as long as the button is held.
// -----------------------------------------------------------------------------
module display_scheduler #(
    parameter int LIGHTS_DWELL = 8,
    parameter int DICE_DWELL   = 4,
    parameter int HOLD_CYCLES  = 6,
    parameter int CW           = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       button,
    input  logic [2:0] lights,
    input  logic [2:0] throw,
    output logic       sel,
    output logic       roll,
    output logic [2:0] result,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_LIGHTS = 2'd0,
        ST_DICE   = 2'd1,
        ST_ROLL   = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    localparam logic [CW-1:0] CNT_ZERO    = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE     = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] LIGHTS_LAST = CW'(LIGHTS_DWELL - 1);
    localparam logic [CW-1:0] DICE_LAST   = CW'(DICE_DWELL - 1);
    localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);
    localparam logic [2:0]    RED_ONLY    = 3'b001;

    // A captured throw outside 1..6 is shown as a one so the display never
    // presents an impossible face.
    function automatic logic [2:0] sanitize_throw(input logic [2:0] t);
        logic [2:0] v;
        if ((t == 3'd0) || (t == 3'd7)) begin
            v = 3'd1;
        end else begin
            v = t;
        end
        return v;
    endfunction

    state_t        r_state;
    state_t        w_next_state;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_next_cnt;
    logic          r_button_q;
    logic          r_armed;
    logic [2:0]    r_cap;
    logic          w_capture;
    logic          w_rise;
    logic          w_timeout;
    logic          r_sel;
    logic          r_roll;
    logic          r_busy;
    logic [2:0]    r_result;

    // A press only counts once the button has been seen released since reset
    // (or since a forced timeout), so a button held through reset or through
    // a timeout cannot start a roll by itself.
    assign w_rise = button & ~r_button_q & r_armed;

`ifdef ROLL_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'd999;

    logic [15:0] r_roll_timer;

    // Roll timer: counts cycles spent in ROLL, cleared on any other state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_roll_timer <= 16'd0;
        end else if ((r_state == ST_ROLL) && (w_next_state == ST_ROLL)) begin
            r_roll_timer <= r_roll_timer + 16'd1;
        end else begin
            r_roll_timer <= 16'd0;
        end
    end

    // The timer holds 999 during the 1000th cycle of the roll.
    assign w_timeout = (r_state == ST_ROLL) && button && (r_roll_timer == TIMEOUT_LAST);
`else
    assign w_timeout = 1'b0;
`endif

    // Button history and arming flag used by the rising-edge detector.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_button_q <= 1'b0;
            r_armed    <= 1'b0;
        end else begin
            r_button_q <= button;
            if (w_timeout) begin
                r_armed <= 1'b0;
            end else if (!button) begin
                r_armed <= 1'b1;
            end else begin
                r_armed <= r_armed;
            end
        end
    end

    // Next-state and dwell-counter logic; the counter restarts on every
    // state change.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_capture    = 1'b0;
        case (r_state)
            ST_LIGHTS: begin
                if (w_rise) begin
                    w_next_state = ST_ROLL;
                    w_next_cnt   = CNT_ZERO;
                end else if (r_cnt == LIGHTS_LAST) begin
                    // Hand over to the dice only while the lights show red.
                    if (lights == RED_ONLY) begin
                        w_next_state = ST_DICE;
                        w_next_cnt   = CNT_ZERO;
                    end else begin
                        w_next_cnt   = r_cnt;
                    end
                end else begin
                    w_next_cnt = r_cnt + CNT_ONE;
                end
            end
            ST_DICE: begin
                if (w_rise) begin
                    w_next_state = ST_ROLL;
                    w_next_cnt   = CNT_ZERO;
                end else if (r_cnt == DICE_LAST) begin
                    w_next_state = ST_LIGHTS;
                    w_next_cnt   = CNT_ZERO;
                end else begin
                    w_next_cnt = r_cnt + CNT_ONE;
                end
            end
            ST_ROLL: begin
                if (!button || w_timeout) begin
                    w_next_state = ST_HOLD;
                    w_next_cnt   = CNT_ZERO;
                    w_capture    = 1'b1;
                end else begin
                    w_next_cnt = CNT_ZERO;
                end
            end
            ST_HOLD: begin
                if (w_rise) begin
                    w_next_state = ST_ROLL;
                    w_next_cnt   = CNT_ZERO;
                end else if (r_cnt == HOLD_LAST) begin
                    w_next_state = ST_LIGHTS;
                    w_next_cnt   = CNT_ZERO;
                end else begin
                    w_next_cnt = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_next_state = ST_LIGHTS;
                w_next_cnt   = CNT_ZERO;
            end
        endcase
    end

    // State and dwell-counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_LIGHTS;
            r_cnt   <= CNT_ZERO;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    // Captured throw shown during HOLD.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cap <= 3'b001;
        end else if (w_capture) begin
            r_cap <= sanitize_throw(throw);
        end else begin
            r_cap <= r_cap;
        end
    end

    // Control outputs decoded from the next state so they switch on the
    // transition edge itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel  <= 1'b1;
            r_roll <= 1'b0;
            r_busy <= 1'b0;
        end else begin
            r_sel  <= (w_next_state == ST_LIGHTS);
            r_roll <= (w_next_state == ST_ROLL) & button;
            r_busy <= (w_next_state == ST_ROLL) || (w_next_state == ST_HOLD);
        end
    end

    // Display value: one cycle behind the currently selected source.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_result <= 3'b000;
        end else if (r_sel) begin
            r_result <= lights;
        end else if (r_state == ST_HOLD) begin
            r_result <= r_cap;
        end else begin
            r_result <= throw;
        end
    end

    assign sel    = r_sel;
    assign roll   = r_roll;
    assign busy   = r_busy;
    assign result = r_result;

endmodule

// File: tb/tb_display_scheduler.sv
// -----------------------------------------------------------------------------
// tb_display_scheduler
//
// Directed self-checking bench for display_scheduler with default parameters.
// Inputs are driven 1 time unit after each rising edge and outputs are
// sampled at that same point, i.e. they reflect the state after the edge.
// -----------------------------------------------------------------------------
module tb_display_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       button;
    logic [2:0] lights;
    logic [2:0] throw;
    logic       sel;
    logic       roll;
    logic [2:0] result;
    logic       busy;

    int n_chk = 0;
    int n_err = 0;

    display_scheduler dut (
        .clk    (clk),
        .rst    (rst),
        .button (button),
        .lights (lights),
        .throw  (throw),
        .sel    (sel),
        .roll   (roll),
        .result (result),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        button = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic       exp_sel;
        logic [2:0] exp_res;
        logic [2:0] tv;

        rst    = 1'b1;
        button = 1'b1;
        lights = 3'b001;
        throw  = 3'd3;

        // ---- reset with button held -------------------------------------
        tick();
        tick();
        check_eq("rst_sel",    16'(sel),    16'd1);
        check_eq("rst_roll",   16'(roll),   16'd0);
        check_eq("rst_result", 16'(result), 16'd0);
        check_eq("rst_busy",   16'(busy),   16'd0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("held_no_roll_busy", 16'(busy), 16'd0);
            check_eq("held_no_roll_roll", 16'(roll), 16'd0);
        end
        button = 1'b0;
        tick();
        button = 1'b1;
        tick();
        check_eq("repress_busy", 16'(busy), 16'd1);
        check_eq("repress_roll", 16'(roll), 16'd1);
        check_eq("repress_sel",  16'(sel),  16'd0);

        // ---- default slicing: 8 lights / 4 dice -------------------------
        lights = 3'b001;
        throw  = 3'd6;
        do_reset();
        for (int k = 1; k <= 24; k++) begin
            tick();
            exp_sel = ((k % 12) >= 8) ? 1'b0 : 1'b1;
            exp_res = (((k - 1) % 12) >= 8) ? 3'd6 : 3'd1;
            check_eq("slice_sel",    16'(sel),    16'(exp_sel));
            check_eq("slice_result", 16'(result), 16'(exp_res));
        end

        // ---- red gating --------------------------------------------------
        lights = 3'b100;
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            tick();
        end
        check_eq("green_hold_sel",    16'(sel),    16'd1);
        check_eq("green_hold_result", 16'(result), 16'd4);
        lights = 3'b001;
        tick();
        check_eq("red_release_sel",    16'(sel),    16'd0);
        check_eq("red_release_result", 16'(result), 16'd1);

        // ---- roll and hold -----------------------------------------------
        lights = 3'b001;
        throw  = 3'd2;
        do_reset();
        tick();
        tick();
        button = 1'b1;
        tick();
        check_eq("roll_sel",  16'(sel),  16'd0);
        check_eq("roll_roll", 16'(roll), 16'd1);
        check_eq("roll_busy", 16'(busy), 16'd1);
        for (int i = 1; i <= 4; i++) begin
            tick();
            check_eq("roll_held", 16'(roll), 16'd1);
        end
        check_eq("roll_live_result", 16'(result), 16'd2);
        button = 1'b0;
        throw  = 3'd4;
        tick();
        check_eq("hold_entry_busy", 16'(busy), 16'd1);
        check_eq("hold_entry_roll", 16'(roll), 16'd0);
        check_eq("hold_entry_sel",  16'(sel),  16'd0);
        for (int k = 1; k <= 6; k++) begin
            tv    = (k < 4) ? 3'(k) : 3'(k + 1);
            throw = tv;
            tick();
            check_eq("hold_result", 16'(result), 16'd4);
            check_eq("hold_busy",   16'(busy),   (k <= 5) ? 16'd1 : 16'd0);
            check_eq("hold_sel",    16'(sel),    (k <= 5) ? 16'd0 : 16'd1);
        end
        tick();
        check_eq("after_hold_result", 16'(result), 16'd1);

        // ---- illegal throw and re-roll ------------------------------------
        lights = 3'b001;
        throw  = 3'd2;
        do_reset();
        tick();
        button = 1'b1;
        tick();
        button = 1'b0;
        throw  = 3'd7;
        tick();
        throw = 3'd5;
        tick();
        check_eq("illegal_cap_result", 16'(result), 16'd1);
        tick();
        button = 1'b1;
        tick();
        check_eq("reroll_roll", 16'(roll), 16'd1);
        check_eq("reroll_busy", 16'(busy), 16'd1);
        check_eq("reroll_sel",  16'(sel),  16'd0);
        button = 1'b0;
        throw  = 3'd3;
        tick();
        throw = 3'd5;
        for (int k = 1; k <= 5; k++) begin
            tick();
            check_eq("reroll_hold_busy", 16'(busy), 16'd1);
        end
        check_eq("reroll_hold_result", 16'(result), 16'd3);
        tick();
        check_eq("reroll_exit_busy", 16'(busy), 16'd0);
        check_eq("reroll_exit_sel",  16'(sel),  16'd1);

        // ---- reset in the middle of HOLD --------------------------------
        tick();
        button = 1'b1;
        tick();
        button = 1'b0;
        tick();
        check_eq("pre_rst_busy", 16'(busy), 16'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("mid_rst_busy",   16'(busy),   16'd0);
        check_eq("mid_rst_sel",    16'(sel),    16'd1);
        check_eq("mid_rst_result", 16'(result), 16'd0);

        // ---- long button hold ---------------------------------------------
        lights = 3'b001;
        throw  = 3'd2;
        do_reset();
        tick();
        button = 1'b1;
        tick();
        for (int j = 1; j <= 1199; j++) begin
            tick();
`ifdef ROLL_TIMEOUT_EN
            if (j == 999) begin
                check_eq("pre_timeout_roll", 16'(roll), 16'd1);
            end
            if (j == 1000) begin
                check_eq("timeout_roll", 16'(roll), 16'd0);
                check_eq("timeout_busy", 16'(busy), 16'd1);
            end
`endif
        end
`ifdef ROLL_TIMEOUT_EN
        check_eq("post_timeout_busy", 16'(busy), 16'd0);
        check_eq("post_timeout_roll", 16'(roll), 16'd0);
        button = 1'b0;
        tick();
        button = 1'b1;
        tick();
        check_eq("post_timeout_reroll", 16'(roll), 16'd1);
        check_eq("post_timeout_rebusy", 16'(busy), 16'd1);
`else
        check_eq("long_roll_roll", 16'(roll), 16'd1);
        check_eq("long_roll_busy", 16'(busy), 16'd1);
        check_eq("long_roll_sel",  16'(sel),  16'd0);
        button = 1'b0;
        tick();
        check_eq("long_release_roll", 16'(roll), 16'd0);
        check_eq("long_release_busy", 16'(busy), 16'd1);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
